// File: rtl/rx_edge_filter_detect.sv
// Per-channel RX front end: synchroniser, glitch filter and direction-qualified edge pulse.
// Optional sticky edge flags are built only when RX_EDGE_STICKY_EN is defined.
module rx_edge_filter_detect #(
  parameter int   CH_NUM      = 1,
  parameter int   SYNC_STAGES = 2,
  parameter int   FILTER_LEN  = 4,
  parameter logic IDLE_LEVEL  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CH_NUM-1:0]     rx_pin_in,
  input  logic [2*CH_NUM-1:0]   mode_i,
  output logic [CH_NUM-1:0]     level_o,
  output logic [CH_NUM-1:0]     edge_o,
  output logic                  any_edge_o,
  input  logic [CH_NUM-1:0]     sticky_clr_i,
  output logic [CH_NUM-1:0]     sticky_o
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  logic [CH_NUM-1:0] level_vec;
  logic [CH_NUM-1:0] edge_vec;

  genvar gi;
  generate
    for (gi = 0; gi < CH_NUM; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   sample;
      logic [CNT_W-1:0]       cnt_q, cnt_d;
      logic                   level_q, level_d;
      logic                   edge_q, edge_d;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
        end else begin
          sync_q <= {sync_q[SYNC_STAGES-2:0], rx_pin_in[gi]};
        end
      end

      assign sample = sync_q[SYNC_STAGES-1];

      // A new level is accepted only after FILTER_LEN consecutive differing samples;
      // any matching sample in between restarts the run.
      always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        edge_d  = 1'b0;
        if (sample == level_q) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
          level_d = sample;
          cnt_d   = '0;
          // Old level high means a falling edge (mode bit0), else rising (mode bit1).
          edge_d  = level_q ? mode_i[2*gi] : mode_i[2*gi+1];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q   <= '0;
          level_q <= IDLE_LEVEL;
          edge_q  <= 1'b0;
        end else begin
          cnt_q   <= cnt_d;
          level_q <= level_d;
          edge_q  <= edge_d;
        end
      end

      assign level_vec[gi] = level_q;
      assign edge_vec[gi]  = edge_q;
    end
  endgenerate

  assign level_o    = level_vec;
  assign edge_o     = edge_vec;
  assign any_edge_o = |edge_vec;

`ifdef RX_EDGE_STICKY_EN
  logic [CH_NUM-1:0] sticky_q, sticky_d;

  // Setting from a pulse takes priority over a simultaneous clear.
  always_comb begin
    sticky_d = edge_vec | (sticky_q & ~sticky_clr_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky_o = sticky_q;
`else
  logic unused_sticky_clr;
  assign unused_sticky_clr = ^sticky_clr_i;
  assign sticky_o          = '0;
`endif

endmodule

// File: tb/tb_rx_edge_filter_detect.sv
// Directed bench for rx_edge_filter_detect (4 channels, default filter) with a
// window-based reference model checked every cycle plus literal expectations.
module tb_rx_edge_filter_detect;
  localparam int   CH   = 4;
  localparam int   SYNC = 2;
  localparam int   FL   = 4;
  localparam logic IDLE = 1'b1;
`ifdef RX_EDGE_STICKY_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic [CH-1:0]   rx_pin_in;
  logic [2*CH-1:0] mode_i;
  logic [CH-1:0]   level_o;
  logic [CH-1:0]   edge_o;
  logic            any_edge_o;
  logic [CH-1:0]   sticky_clr_i;
  logic [CH-1:0]   sticky_o;

  rx_edge_filter_detect #(
    .CH_NUM(CH), .SYNC_STAGES(SYNC), .FILTER_LEN(FL), .IDLE_LEVEL(IDLE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_pin_in(rx_pin_in), .mode_i(mode_i),
    .level_o(level_o), .edge_o(edge_o), .any_edge_o(any_edge_o),
    .sticky_clr_i(sticky_clr_i), .sticky_o(sticky_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a channel flips level when the last FL synchronised samples
  // (all taken after its previous flip or reset) differ from its current level.
  logic [CH-1:0] ph [0:4095];
  int            k = 0;
  int            rst_k = 0;
  int            last_acc [CH];
  logic [CH-1:0] m_lvl, m_edge, m_sticky;

  function automatic logic s_at(int j, int c);
    if (j - SYNC <= rst_k) return IDLE;
    return ph[j-SYNC][c];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_k    = k;
      m_lvl    = {CH{IDLE}};
      m_edge   = '0;
      m_sticky = '0;
      for (int c = 0; c < CH; c++) last_acc[c] = k;
    end else begin
      if (STK) m_sticky = m_edge | (m_sticky & ~sticky_clr_i);
      if (k < 4095) k++;
      ph[k] = rx_pin_in;
      for (int c = 0; c < CH; c++) begin
        bit acc;
        acc = (k - FL + 1 > last_acc[c]);
        for (int j = k - FL + 1; j <= k; j++)
          if (s_at(j, c) == m_lvl[c]) acc = 1'b0;
        m_edge[c] = 1'b0;
        if (acc) begin
          m_edge[c]   = m_lvl[c] ? mode_i[2*c] : mode_i[2*c+1];
          m_lvl[c]    = ~m_lvl[c];
          last_acc[c] = k;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_level", 32'(level_o), 32'(m_lvl));
      chk("model_edge", 32'(edge_o), 32'(m_edge));
      chk("model_any", 32'(any_edge_o), 32'(|m_edge));
      chk("model_sticky", 32'(sticky_o), 32'(m_sticky));
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_count(input int n, input logic [CH-1:0] mask, inout int cnt);
    repeat (n) begin
      @(negedge clk);
      if ((edge_o & mask) != '0) cnt++;
    end
  endtask

  int c1, c2;

  initial begin
    rst_n        = 1'b0;
    rx_pin_in    = '1;
    mode_i       = '0;
    sticky_clr_i = '0;
    wait_cyc(3);
    chk("rst_level", 32'(level_o), 32'hF);
    chk("rst_edge", 32'(edge_o), 32'h0);
    chk("rst_any", 32'(any_edge_o), 32'h0);
    chk("rst_sticky", 32'(sticky_o), 32'h0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    wait_cyc(3);

    // Single falling edge on ch0, mode fall
    mode_i    = 8'h01;
    rx_pin_in = 4'b1110;
    wait_cyc(5);
    chk("t1_pre", 32'(edge_o), 32'h0);
    wait_cyc(1);
    chk("t1_edge", 32'(edge_o), 32'h1);
    chk("t1_any", 32'(any_edge_o), 32'h1);
    wait_cyc(1);
    chk("t1_after", 32'(edge_o), 32'h0);
    chk("t1_level", 32'(level_o), 32'hE);
    wait_cyc(8);

    // 3-cycle glitch on ch1 rejected, then a full fall takes full latency again
    mode_i    = 8'h05;
    c1        = 0;
    rx_pin_in = 4'b1100;
    run_count(3, 4'b0010, c1);
    rx_pin_in = 4'b1110;
    run_count(12, 4'b0010, c1);
    chk("t2_pulses", 32'(c1), 32'd0);
    chk("t2_level", 32'(level_o), 32'hE);
    rx_pin_in = 4'b1100;
    wait_cyc(5);
    chk("t2_pre", 32'(edge_o), 32'h0);
    wait_cyc(1);
    chk("t2_edge", 32'(edge_o), 32'h2);
    wait_cyc(8);

    // ch2 rise-only, then both directions
    mode_i = 8'h20;
    c1 = 0; c2 = 0;
    rx_pin_in = 4'b1000;
    run_count(10, 4'b0100, c1);
    rx_pin_in = 4'b1100;
    run_count(10, 4'b0100, c2);
    chk("t3_rise_fall", 32'(c1), 32'd0);
    chk("t3_rise_rise", 32'(c2), 32'd1);
    mode_i = 8'h30;
    c1 = 0; c2 = 0;
    rx_pin_in = 4'b1000;
    run_count(10, 4'b0100, c1);
    rx_pin_in = 4'b1100;
    run_count(10, 4'b0100, c2);
    chk("t3_both_fall", 32'(c1), 32'd1);
    chk("t3_both_rise", 32'(c2), 32'd1);

    // All channels idle high (edges dropped with mode off), then simultaneous fall
    mode_i    = 8'h00;
    rx_pin_in = 4'b1111;
    wait_cyc(10);
    chk("t4_level_hi", 32'(level_o), 32'hF);
    mode_i    = 8'b10110001;
    rx_pin_in = 4'b0000;
    wait_cyc(5);
    chk("t4_pre", 32'(edge_o), 32'h0);
    wait_cyc(1);
    chk("t4_edge", 32'(edge_o), 32'h5);
    chk("t4_any", 32'(any_edge_o), 32'h1);
    wait_cyc(1);
    chk("t4_after", 32'(edge_o), 32'h0);
    chk("t4_level", 32'(level_o), 32'h0);
    wait_cyc(5);

    // Reset in the middle of a pending rise (count 2)
    mode_i    = 8'hFF;
    rx_pin_in = 4'b1111;
    wait_cyc(4);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_level", 32'(level_o), 32'hF);
    chk("t5_rst_edge", 32'(edge_o), 32'h0);
    chk("t5_rst_any", 32'(any_edge_o), 32'h0);
    wait_cyc(2);
    rst_n = 1'b1;
    c1 = 0;
    run_count(10, 4'b1111, c1);
    chk("t5_no_edge", 32'(c1), 32'd0);
    rx_pin_in = 4'b0000;
    wait_cyc(5);
    chk("t5_pre", 32'(edge_o), 32'h0);
    wait_cyc(1);
    chk("t5_edge", 32'(edge_o), 32'hF);
    wait_cyc(3);

    // Sticky: set coinciding with clear wins; clear alone clears next cycle
    sticky_clr_i = 4'hF;
    wait_cyc(1);
    sticky_clr_i = 4'h0;
    wait_cyc(1);
    chk("t6_cleared", 32'(sticky_o), 32'h0);
    rx_pin_in = 4'b0001;
    wait_cyc(6);
    chk("t6_edge", 32'(edge_o), 32'h1);
    sticky_clr_i = 4'h1;
    wait_cyc(1);
    sticky_clr_i = 4'h0;
    chk("t6_set_wins", 32'(sticky_o[0]), 32'(STK));
    wait_cyc(3);
    chk("t6_hold", 32'(sticky_o[0]), 32'(STK));
    sticky_clr_i = 4'h1;
    wait_cyc(1);
    sticky_clr_i = 4'h0;
    chk("t6_clr", 32'(sticky_o[0]), 32'h0);
    wait_cyc(5);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
